// File: rtl/sudoku_wb_host.sv
// Wishbone classic initiator: converts one valid/ready command into one bus cycle
// and returns read data or a timeout indication on a valid/ready response stream.
module sudoku_wb_host #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_timeout;
    logic [15:0] w_cnt_inc;
    logic [15:0] r_to_cnt;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;

    // Counter holds the number of completed ack-less BUS cycles, so the
    // incremented value equals the number of cycles stb has been high so far.
    assign w_cnt_inc = r_to_cnt + 16'd1;
    assign w_timeout = (w_cnt_inc == TO_LIMIT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i || w_timeout) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_to_cnt  <= 16'd0;
            r_we      <= 1'b0;
            r_adr     <= 32'd0;
            r_dat     <= 32'd0;
            r_sel     <= 4'd0;
            r_rsp_dat <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_to_cnt <= 16'd0;
                r_we     <= cmd_we;
                r_adr    <= cmd_adr;
                r_dat    <= cmd_dat;
                r_sel    <= cmd_sel;
            end
            // Ack takes priority over a timeout expiring in the same cycle.
            if (r_state == ST_BUS) begin
                if (wbm_ack_i) begin
                    r_rsp_dat <= r_we ? 32'd0 : wbm_dat_i;
                    r_rsp_err <= 1'b0;
                end else begin
                    r_to_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_rsp_dat <= 32'hFFFF_FFFF;
                        r_rsp_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);
    assign wbm_cyc_o = (r_state == ST_BUS);
    assign wbm_stb_o = (r_state == ST_BUS);
    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_sudoku_wb_host.sv
// Self-checking bench for sudoku_wb_host: directed cases followed by random
// transactions compared against a transaction-level model of the host.
module tb_sudoku_wb_host;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    int n_tests = 0;
    int n_fail  = 0;

    sudoku_wb_host #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from a negedge in IDLE. ack_at: stb cycle on which the
    // slave acks (0 = never). bp: response back-pressure cycles. Returns at the
    // negedge of the first IDLE cycle after the response handshake.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                           input int bp, input logic late_ack, input logic hold_next);
        int          n_stb;
        bit          done;
        bit          acked;
        int          exp_stb;
        logic [31:0] exp_dat;
        logic        exp_err;
        // Transaction-level model: the slave answers only if it acks within the
        // timeout window; otherwise stb stays up for exactly T cycles.
        acked   = (ack_at >= 1) && (ack_at <= T);
        exp_stb = acked ? ack_at : T;
        exp_err = !acked;
        exp_dat = !acked ? 32'hFFFF_FFFF : (we ? 32'd0 : rdat);

        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);

        n_stb = 0;
        done  = 1'b0;
        for (int c = 1; c <= T + 5 && !done; c++) begin
            if (wbm_stb_o !== 1'b1) begin
                done = 1'b1;
            end else begin
                n_stb++;
                check("bus_cyc", wbm_cyc_o, 1'b1);
                check("bus_we", wbm_we_o, we);
                check("bus_adr", wbm_adr_o, adr);
                check("bus_dat", wbm_dat_o, dat);
                check("bus_sel", wbm_sel_o, sel);
                check("bus_busy", busy, 1'b1);
                check("bus_rsp_valid", rsp_valid, 1'b0);
                check("bus_cmd_ready", cmd_ready, 1'b0);
                wbm_ack_i = (c == ack_at);
                wbm_dat_i = (c == ack_at) ? rdat : $urandom;
                @(negedge clk);
            end
        end
        wbm_ack_i = 1'b0;

        check("stb_cycles", n_stb, exp_stb);
        check("resp_cyc", wbm_cyc_o, 1'b0);
        check("resp_stb", wbm_stb_o, 1'b0);
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_dat", rsp_dat, exp_dat);
        check("resp_err", rsp_err, exp_err);
        check("resp_cmd_ready", cmd_ready, 1'b0);

        cmd_valid = hold_next;
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            wbm_ack_i = late_ack;
            wbm_dat_i = $urandom;
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_dat", rsp_dat, exp_dat);
            check("bp_err", rsp_err, exp_err);
            check("bp_cmd_ready", cmd_ready, 1'b0);
            check("bp_stb", wbm_stb_o, 1'b0);
        end
        rsp_ready = 1'b1;
        wbm_ack_i = late_ack;
        @(negedge clk);
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        check("post_valid", rsp_valid, 1'b0);
        check("post_cmd_ready", cmd_ready, 1'b1);
        check("post_busy", busy, 1'b0);
        check("post_stb", wbm_stb_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'd0;
        cmd_dat   = 32'd0;
        cmd_sel   = 4'd0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_stb", wbm_stb_o, 1'b0);
        check("rst_we", wbm_we_o, 1'b0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_dat", wbm_dat_o, 32'd0);
        check("rst_sel", wbm_sel_o, 4'd0);

        // Write acked on the 3rd stb cycle.
        run_txn(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 3, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        // Read acked immediately: best-case latency.
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'h1234_5678, 0, 1'b0, 1'b0);
        // Read with no ack: timeout, then a late ack that must be ignored.
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h0, 2, 1'b1, 1'b0);
        // Ack on the last legal cycle wins over the timeout.
        run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, T, 32'h0000_00C3, 0, 1'b0, 1'b0);
        // Back-pressure with the next command already offered.
        run_txn(1'b1, 32'h3000_0030, 32'h0BAD_F00D, 4'h3, 2, 32'h0, 5, 1'b0, 1'b1);
        run_txn(1'b0, 32'h3000_0034, 32'h0, 4'hC, 2, 32'hCAFE_0042, 0, 1'b0, 1'b0);

        // Reset during the 2nd stb cycle discards the command.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0040;
        cmd_sel   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rstmid_stb1", wbm_stb_o, 1'b1);
        @(negedge clk);
        check("rstmid_stb2", wbm_stb_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_cyc", wbm_cyc_o, 1'b0);
        check("rstmid_stb", wbm_stb_o, 1'b0);
        check("rstmid_valid", rsp_valid, 1'b0);
        check("rstmid_cmd_ready", cmd_ready, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wbm_ack_i = 1'(i % 2);
            @(negedge clk);
            check("rstmid_no_rsp", rsp_valid, 1'b0);
        end
        wbm_ack_i = 1'b0;

        for (int n = 0; n < 25; n++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, T + 2)), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
